// File: rtl/pc_sequencer.sv
// Program-counter sequencer: run/step/halt control FSM, next-PC adder and
// saturating executed-instruction counter.
module pc_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    input  logic       halt_instr,
    input  logic       branch_en,
    input  logic [5:0] branch_offset,
    input  logic [5:0] pc_current,
    output logic       run,
    output logic       c3,
    output logic [5:0] pc_next,
    output logic [1:0] state,
    output logic [7:0] instr_count
);

    localparam int unsigned PC_W  = 6;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        STEP   = 2'b10,
        HALTED = 2'b11
    } state_t;

    state_t state_q;
    state_t state_d;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and combinational control outputs
    always_comb begin
        state_d = state_q;
        run     = 1'b0;
        c3      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end else if (step) begin
                    state_d = STEP;
                end
            end
            RUN: begin
                run = 1'b1;
                if (halt_instr) begin
                    state_d = HALTED;
                end else if (stop) begin
                    state_d = IDLE;
                end
            end
            STEP: begin
                run     = 1'b1;
                state_d = halt_instr ? HALTED : IDLE;
            end
            default: begin
                state_d = HALTED;
            end
        endcase
        // PC freezes on the HALT instruction address
        c3 = run & ~halt_instr;
    end

    // Six-bit modular add makes the sign extension of the offset implicit
    always_comb begin
        pc_next = pc_current + PC_W'(1) + (branch_en ? branch_offset : PC_W'(0));
    end

    // Executed-instruction counter, saturating at all-ones
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_count <= '0;
        end else if (c3 && (instr_count != {CNT_W{1'b1}})) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       step = 1'b0;
    logic       halt_instr = 1'b0;
    logic       branch_en = 1'b0;
    logic [5:0] branch_offset = 6'd0;
    logic [5:0] pc_current = 6'd0;
    logic       run;
    logic       c3;
    logic [5:0] pc_next;
    logic [1:0] state;
    logic [7:0] instr_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt;
    int exp_pc;

    pc_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .step          (step),
        .halt_instr    (halt_instr),
        .branch_en     (branch_en),
        .branch_offset (branch_offset),
        .pc_current    (pc_current),
        .run           (run),
        .c3            (c3),
        .pc_next       (pc_next),
        .state         (state),
        .instr_count   (instr_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0; stop = 1'b0; step = 1'b0; halt_instr = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_state", state, 0);
        check("rst_run", run, 0);
        check("rst_c3", c3, 0);
        check("rst_cnt", instr_count, 0);
        tick();
        reset = 1'b0;
        tick(); tick();
        check("idle_hold", state, 0);
        check("idle_c3", c3, 0);

        // Next-PC arithmetic and wrap
        pc_current = 6'd63; branch_en = 1'b0; #1;
        check("pc_wrap_up", pc_next, 0);
        pc_current = 6'd0; branch_en = 1'b1; branch_offset = 6'b111110; #1;
        check("pc_wrap_down", pc_next, 63);
        pc_current = 6'd10; branch_offset = 6'd5; #1;
        check("pc_branch_fwd", pc_next, 16);
        branch_en = 1'b0;

        // Continuous run from 32; start beats step
        pc_current = 6'd32; exp_pc = 32; exp_cnt = 0;
        start = 1'b1; step = 1'b1;
        tick();
        start = 1'b0; step = 1'b0; #1;
        check("run_state", state, 1);
        for (int i = 0; i < 3; i++) begin
            check("run_run", run, 1);
            check("run_c3", c3, 1);
            check("run_pc", pc_next, (exp_pc + 1) % 64);
            check("run_cnt", instr_count, exp_cnt);
            tick();
            exp_cnt++;
            exp_pc = (exp_pc + 1) % 64;
            pc_current = 6'(exp_pc);
            #1;
        end
        check("run_cnt3", instr_count, 3);

        // Stop: the stop cycle still executes
        stop = 1'b1; #1;
        check("stop_c3", c3, 1);
        tick();
        stop = 1'b0; exp_cnt++;
        check("stop_state", state, 0);
        check("stop_cnt", instr_count, exp_cnt);

        // Single step pulse
        step = 1'b1;
        tick();
        step = 1'b0; #1;
        check("step_state", state, 2);
        check("step_run", run, 1);
        check("step_c3", c3, 1);
        tick();
        exp_cnt++;
        check("step_back", state, 0);
        check("step_cnt", instr_count, exp_cnt);
        tick();
        check("step_once", instr_count, exp_cnt);

        // Held step re-steps every other cycle
        step = 1'b1;
        tick(); check("hold_s1", state, 2);
        tick(); check("hold_i1", state, 0);
        tick(); check("hold_s2", state, 2);
        step = 1'b0;
        tick(); check("hold_i2", state, 0);
        exp_cnt += 2;
        check("hold_cnt", instr_count, exp_cnt);

        // Halt during step
        step = 1'b1;
        tick();
        step = 1'b0; halt_instr = 1'b1; #1;
        check("sh_c3", c3, 0);
        tick();
        halt_instr = 1'b0;
        check("sh_state", state, 3);
        check("sh_cnt", instr_count, exp_cnt);

        // Saturation at 255
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 254; i++) tick();
        check("sat_254", instr_count, 254);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_255", instr_count, 255);
        end

        // Halt wins over stop; halted ignores start/stop/step
        halt_instr = 1'b1; stop = 1'b1; #1;
        check("halt_c3", c3, 0);
        check("halt_run", run, 1);
        tick();
        halt_instr = 1'b0; stop = 1'b0;
        check("halt_state", state, 3);
        check("halt_run0", run, 0);
        start = 1'b1; step = 1'b1;
        tick(); tick();
        stop = 1'b1;
        tick();
        start = 1'b0; step = 1'b0; stop = 1'b0;
        check("halt_sticky", state, 3);
        check("halt_cnt", instr_count, 255);

        // Asynchronous reset between edges mid-run
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        check("pre_ar_cnt", instr_count, 2);
        #2;
        reset = 1'b1;
        #1;
        check("ar_state", state, 0);
        check("ar_run", run, 0);
        check("ar_c3", c3, 0);
        check("ar_cnt", instr_count, 0);
        tick();
        reset = 1'b0;
        tick();
        check("ar_idle", state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port: clock  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high; forces reset state immediately.
REQ-003 SHALL have port: start  input  1  begin continuous execution (sampled level).
REQ-004 SHALL have port: stop  input  1  pause continuous execution (sampled level).
REQ-005 SHALL have port: step  input  1  execute exactly one instruction from idle (single-cycle pulse).
REQ-006 SHALL have port: halt_instr  input  1  current instruction decodes as HALT.
REQ-007 SHALL have port: branch_en  input  1  current instruction is a taken branch/jump.
REQ-008 SHALL have port: branch_offset  input  6  two's-complement offset relative to PC+1.
REQ-009 SHALL have port: pc_current  input  6  present program-counter value.
REQ-010 SHALL have port: run  output  1  PC-register update enable.
REQ-011 SHALL have port: c3  output  1  PC-register load strobe.
REQ-012 SHALL have port: pc_next  output  6  value to be loaded into the PC register.
REQ-013 SHALL have port: state  output  2  FSM state encoding per REQ-015.
REQ-014 SHALL have port: instr_count  output  8  count of executed (PC-loading) cycles.

Function
REQ-015 SHALL implement FSM states IDLE=2'b00, RUN=2'b01, STEP=2'b10, HALTED=2'b11, registered.
REQ-016 IDLE: start -> RUN; else step -> STEP; else stay; start SHALL take priority over simultaneous step.
REQ-017 RUN: halt_instr -> HALTED; else stop -> IDLE; else stay; halt_instr SHALL take priority over simultaneous stop; start and step SHALL be ignored.
REQ-018 STEP: unconditionally -> IDLE after exactly one cycle, unless halt_instr asserted in that cycle -> HALTED.
REQ-019 HALTED: SHALL remain until reset; start, stop, step SHALL be ignored.
REQ-020 run SHALL be combinational: 1 when state is RUN or STEP, else 0.
REQ-021 c3 SHALL be combinational: run AND NOT halt_instr, so the PC freezes on the HALT instruction address.
REQ-022 pc_next SHALL be combinational: pc_current+1 when branch_en=0; pc_current+1+sign_extend(branch_offset) when branch_en=1; all arithmetic modulo 64 (wrap 63+1 -> 0, 0+1-2 -> 63).
REQ-023 pc_next SHALL be computed regardless of state; it only takes effect when c3=1.
REQ-024 instr_count SHALL increment by 1 on each rising edge where c3=1, saturating at 255 (no wrap).
REQ-025 stop SHALL take effect at the next edge: the cycle in which stop is sampled still executes (c3=1 if no halt).
REQ-026 A step pulse held high for multiple cycles SHALL produce one STEP then IDLE; re-entry to STEP requires step sampled high again in IDLE (level, not edge: held step re-steps every other cycle).
REQ-027 Block SHALL contain no combinational path from state outputs back to inputs; run/c3/pc_next depend only on state and current inputs.

Reset
REQ-028 On reset assertion state SHALL become IDLE and instr_count 0 asynchronously; run=0, c3=0 immediately.
REQ-029 Reset asserted mid-RUN or mid-STEP SHALL abort without a further count increment; HALTED SHALL be exited only by reset.
REQ-030 After reset deassertion the block SHALL remain IDLE until start or step sampled high.

Verification
REQ-031 Reset, start=1 one cycle, pc_current tracks pc_next from 6'd32 -> state RUN, run=1, c3=1, pc_next 33,34,35...; instr_count increments each cycle.
REQ-032 pc_current=63, branch_en=0 -> pc_next=0; pc_current=0, branch_en=1, branch_offset=6'b111110 (-2) -> pc_next=63; pc_current=10, offset=5 -> pc_next=16.
REQ-033 IDLE, step pulse 1 cycle -> exactly one cycle with run=1, c3=1, instr_count +1, state returns to 00.
REQ-034 RUN, halt_instr=1 and stop=1 same cycle -> c3=0 that cycle, state 11 next, subsequent start/step ignored, count frozen.
REQ-035 RUN with instr_count=254, three more executing cycles -> count 255, stays 255.
REQ-036 RUN, reset pulsed asynchronously between edges -> state 00, run=0, c3=0, instr_count 0 before next edge.
